// File: rtl/ifb_queue.sv
// Instruction fetch buffer: in-order queue of fetch groups, icache fills may return out of order.
// Latency: alloc->request next cycle; fill->out next cycle (same cycle with IFB_QUEUE_BYPASS_EN).
// Backpressure: in_ready low at full; req_*/out_* held stable while req_ready/out_ready are low.
module ifb_queue #(
    parameter int DEPTH   = 8,
    parameter int GROUP_N = 4,
    localparam int IW     = $clog2(DEPTH),
    localparam int CW     = $clog2(GROUP_N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_pc,
    input  logic [CW-1:0]        in_cut_pos,
    input  logic                 in_pred_taken,
    input  logic [31:0]          in_pred_target,
    output logic                 req_valid,
    input  logic                 req_ready,
    output logic [31:0]          req_pc,
    output logic [IW:0]          req_tag,
    input  logic                 resp_valid,
    input  logic [IW:0]          resp_tag,
    input  logic [GROUP_N*32-1:0] resp_instr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_pc,
    output logic [CW-1:0]        out_cut_pos,
    output logic                 out_pred_taken,
    output logic [31:0]          out_pred_target,
    output logic [GROUP_N*32-1:0] out_instr
);
    localparam int CNTW = IW + 1;

    typedef enum logic [1:0] {ST_FREE, ST_PEND, ST_INFL, ST_FILL} ent_st_t;

    ent_st_t              r_state     [DEPTH];
    ent_st_t              w_state_nxt [DEPTH];
    logic [31:0]          r_pc        [DEPTH];
    logic [CW-1:0]        r_cut       [DEPTH];
    logic                 r_pt        [DEPTH];
    logic [31:0]          r_tgt       [DEPTH];
    logic [GROUP_N*32-1:0] r_instr    [DEPTH];

    logic [IW-1:0]        r_head;
    logic [IW-1:0]        r_tail;
    logic [CNTW-1:0]      r_count;
    logic                 r_epoch;

    logic                 w_enq;
    logic                 w_deq;
    logic                 w_req_fire;
    logic                 w_resp_acc;
    logic                 w_pend_found;
    logic [IW-1:0]        w_pend_idx;
    logic [IW-1:0]        w_resp_idx;
    logic                 w_bypass;

    assign in_ready   = (r_count < CNTW'(DEPTH));
    assign w_enq      = in_valid && in_ready && !flush;
    assign w_resp_idx = resp_tag[IW-1:0];
    assign w_resp_acc = resp_valid && (resp_tag[IW] == r_epoch) && (r_state[w_resp_idx] == ST_INFL);

`ifdef IFB_QUEUE_BYPASS_EN
    // A fill landing on an in-flight head is forwarded straight to decode.
    assign w_bypass = w_resp_acc && (w_resp_idx == r_head) && !flush;
`else
    assign w_bypass = 1'b0;
`endif

    // Oldest PEND entry in age order: scan backwards from youngest so the oldest hit wins.
    always_comb begin
        w_pend_found = 1'b0;
        w_pend_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (r_state[r_head + IW'(i)] == ST_PEND) begin
                w_pend_found = 1'b1;
                w_pend_idx   = r_head + IW'(i);
            end
        end
    end

    assign req_valid  = w_pend_found && !flush;
    assign w_req_fire = req_valid && req_ready;
    assign req_pc     = req_valid ? r_pc[w_pend_idx] : 32'd0;
    assign req_tag    = req_valid ? {r_epoch, w_pend_idx} : '0;

    assign out_valid       = !flush && ((r_state[r_head] == ST_FILL) || w_bypass);
    assign w_deq           = out_valid && out_ready;
    assign out_pc          = out_valid ? r_pc[r_head]  : 32'd0;
    assign out_cut_pos     = out_valid ? r_cut[r_head] : '0;
    assign out_pred_taken  = out_valid && r_pt[r_head];
    assign out_pred_target = out_valid ? r_tgt[r_head] : 32'd0;
    assign out_instr       = !out_valid ? '0 : (w_bypass ? resp_instr : r_instr[r_head]);

    // Per-entry next state; dequeue is applied last so a bypassed head goes straight to FREE.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_state_nxt[i] = r_state[i];
        end
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                w_state_nxt[i] = ST_FREE;
            end
        end else begin
            if (w_enq)      w_state_nxt[r_tail]     = ST_PEND;
            if (w_req_fire) w_state_nxt[w_pend_idx] = ST_INFL;
            if (w_resp_acc) w_state_nxt[w_resp_idx] = ST_FILL;
            if (w_deq)      w_state_nxt[r_head]     = ST_FREE;
        end
    end

    // Entry states, pointers, occupancy and epoch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_state[i] <= ST_FREE;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_epoch <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_state[i] <= w_state_nxt[i];
            end
            if (flush) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
                r_epoch <= !r_epoch;
            end else begin
                if (w_enq) r_tail <= r_tail + IW'(1);
                if (w_deq) r_head <= r_head + IW'(1);
                case ({w_enq, w_deq})
                    2'b10:   r_count <= r_count + CNTW'(1);
                    2'b01:   r_count <= r_count - CNTW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Entry payload; only meaningful while the entry state says so, hence no reset.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_pc[r_tail]  <= in_pc;
            r_cut[r_tail] <= in_cut_pos;
            r_pt[r_tail]  <= in_pred_taken;
            r_tgt[r_tail] <= in_pred_target;
        end
        if (w_resp_acc && !flush) begin
            r_instr[w_resp_idx] <= resp_instr;
        end
    end

endmodule

// File: tb/tb_ifb_queue.sv
// Bench for ifb_queue (DEPTH=8, GROUP_N=4): table-driven fill/drain plus hand-written corner sequences.
// Expected head contents come from a scoreboard queue pushed at enqueue time.
// Inputs driven 1ns after the rising edge; outputs sampled there too.
`timescale 1ns/1ps
module tb_ifb_queue;
    localparam int DEPTH   = 8;
    localparam int GROUP_N = 4;
    localparam int IW      = 3;
    localparam int CW      = 2;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  flush = 1'b0;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [31:0]           in_pc = '0;
    logic [CW-1:0]         in_cut_pos = '0;
    logic                  in_pred_taken = 1'b0;
    logic [31:0]           in_pred_target = '0;
    logic                  req_valid;
    logic                  req_ready = 1'b0;
    logic [31:0]           req_pc;
    logic [IW:0]           req_tag;
    logic                  resp_valid = 1'b0;
    logic [IW:0]           resp_tag = '0;
    logic [GROUP_N*32-1:0] resp_instr = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic [31:0]           out_pc;
    logic [CW-1:0]         out_cut_pos;
    logic                  out_pred_taken;
    logic [31:0]           out_pred_target;
    logic [GROUP_N*32-1:0] out_instr;

    ifb_queue #(.DEPTH(DEPTH), .GROUP_N(GROUP_N)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_cut_pos(in_cut_pos),
        .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
        .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc), .req_tag(req_tag),
        .resp_valid(resp_valid), .resp_tag(resp_tag), .resp_instr(resp_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_cut_pos(out_cut_pos),
        .out_pred_taken(out_pred_taken), .out_pred_target(out_pred_target), .out_instr(out_instr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]   pc;
        logic [CW-1:0] cut;
        logic          pt;
        logic [31:0]   tgt;
    } exp_t;

    typedef struct {
        logic [31:0]   pc;
        logic [CW-1:0] cut;
        logic          pt;
        logic [31:0]   tgt;
        logic          exp_rdy;
        logic [IW:0]   exp_tag;
    } vec_t;

    exp_t        sb[$];
    vec_t        tbl[8];
    logic [31:0] ent_pc[DEPTH];
    int          tb_tail = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    logic        exp_byp;

    function automatic logic [GROUP_N*32-1:0] mk_instr(input logic [31:0] pc);
        logic [GROUP_N*32-1:0] r;
        for (int k = 0; k < GROUP_N; k++) r[k*32 +: 32] = (pc + 32'(k * 4)) ^ 32'hC0DE_0000;
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put_enq(input logic [31:0] pc, input logic [CW-1:0] cut, input logic pt, input logic [31:0] tgt);
        exp_t e;
        in_valid = 1'b1; in_pc = pc; in_cut_pos = cut; in_pred_taken = pt; in_pred_target = tgt;
        e.pc = pc; e.cut = cut; e.pt = pt; e.tgt = tgt;
        sb.push_back(e);
        ent_pc[tb_tail] = pc;
        tb_tail = (tb_tail + 1) % DEPTH;
    endtask

    task automatic enq(input logic [31:0] pc, input logic [CW-1:0] cut, input logic pt, input logic [31:0] tgt);
        put_enq(pc, cut, pt, tgt);
        step();
        in_valid = 1'b0;
    endtask

    task automatic enq_pc(input logic [31:0] pc);
        enq(pc, pc[5:4], pc[4], pc + 32'h200);
    endtask

    task automatic issue(input logic [IW:0] exp_tag);
        int w = 0;
        req_ready = 1'b1;
        while (!req_valid && w < 20) begin step(); w++; end
        chk("req_valid", req_valid, 1);
        chk("req_tag", req_tag, exp_tag);
        chk("req_pc", req_pc, ent_pc[exp_tag[IW-1:0]]);
        step();
        req_ready = 1'b0;
    endtask

    task automatic respond(input logic [IW:0] tag);
        resp_valid = 1'b1; resp_tag = tag; resp_instr = mk_instr(ent_pc[tag[IW-1:0]]);
        step();
        resp_valid = 1'b0;
    endtask

    task automatic sb_check(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL %s: dequeue with empty scoreboard, out_pc %0h", name, out_pc);
        end else begin
            e = sb.pop_front();
            chk({name, "_pc"}, out_pc, e.pc);
            chk({name, "_cut"}, out_cut_pos, e.cut);
            chk({name, "_pt"}, out_pred_taken, e.pt);
            chk({name, "_tgt"}, out_pred_target, e.tgt);
            chk({name, "_instr"}, out_instr, mk_instr(e.pc));
        end
    endtask

    task automatic drain_one(input string name);
        int w = 0;
        while (!out_valid && w < 20) begin step(); w++; end
        chk({name, "_out_valid"}, out_valid, 1);
        out_ready = 1'b1;
        sb_check(name);
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 8; i++) begin
            tbl[i].pc      = 32'h1000 + 32'(i * 16);
            tbl[i].cut     = CW'(i);
            tbl[i].pt      = i[0];
            tbl[i].tgt     = 32'h2000 + 32'(i * 64);
            tbl[i].exp_rdy = (i < 7);
            tbl[i].exp_tag = (IW+1)'(i);
        end

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_req_valid", req_valid, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_req_pc", req_pc, 0);
        chk("rst_req_tag", req_tag, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_instr", out_instr, 0);
        rst_n = 1'b1;
        step();

        // Fill / drain from the table
        for (int i = 0; i < 8; i++) begin
            enq(tbl[i].pc, tbl[i].cut, tbl[i].pt, tbl[i].tgt);
            chk("fill_in_ready", in_ready, tbl[i].exp_rdy);
        end
        for (int i = 0; i < 8; i++) issue(tbl[i].exp_tag);
        chk("fill_req_idle", req_valid, 0);
        for (int i = 0; i < 8; i++) respond(tbl[i].exp_tag);
        for (int i = 0; i < 8; i++) drain_one("fill");
        chk("drain_in_ready", in_ready, 1);
        chk("drain_out_valid", out_valid, 0);

        // Out-of-order responses, head = 0
        enq_pc(32'h3000); enq_pc(32'h3010); enq_pc(32'h3020);
        issue(4'd0); issue(4'd1); issue(4'd2);
        respond(4'd2);
        chk("ooo_wait_head", out_valid, 0);
        respond(4'd0);
        chk("ooo_head_ready", out_valid, 1);
        respond(4'd1);
        for (int i = 0; i < 3; i++) drain_one("ooo");

        // Backpressure on request and output, entry 3
        enq_pc(32'h4000);
        for (int i = 0; i < 5; i++) begin
            chk("bp_req_valid", req_valid, 1);
            chk("bp_req_tag", req_tag, 4'd3);
            chk("bp_req_pc", req_pc, 32'h4000);
            step();
        end
        issue(4'd3);
        respond(4'd3);
        for (int i = 0; i < 3; i++) begin
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_pc", out_pc, 32'h4000);
            chk("bp_out_instr", out_instr, mk_instr(32'h4000));
            step();
        end
        drain_one("bp");

        // Response targeting an in-flight head, entry 4
`ifdef IFB_QUEUE_BYPASS_EN
        exp_byp = 1'b1;
`else
        exp_byp = 1'b0;
`endif
        enq_pc(32'h5000);
        issue(4'd4);
        resp_valid = 1'b1; resp_tag = 4'd4; resp_instr = mk_instr(32'h5000); out_ready = 1'b1;
        #1;
        chk("byp_same_cycle", out_valid, exp_byp);
`ifdef IFB_QUEUE_BYPASS_EN
        sb_check("byp");
        step();
        resp_valid = 1'b0; out_ready = 1'b0;
        chk("byp_freed", out_valid, 0);
`else
        step();
        resp_valid = 1'b0;
        chk("byp_next_cycle", out_valid, 1);
        sb_check("byp");
        step();
        out_ready = 1'b0;
        chk("byp_freed", out_valid, 0);
`endif

        // Flush with outstanding requests, entries 5,6 at epoch 0
        enq_pc(32'h6000); enq_pc(32'h6010);
        issue(4'd5); issue(4'd6);
        respond(4'd5);
        chk("pre_flush_out_valid", out_valid, 1);
        enq_pc(32'h6020);
        flush = 1'b1; req_ready = 1'b1; in_valid = 1'b1; in_pc = 32'hBAD0;
        #1;
        chk("flush_req_valid", req_valid, 0);
        chk("flush_out_valid", out_valid, 0);
        step();
        flush = 1'b0; req_ready = 1'b0; in_valid = 1'b0;
        sb.delete();
        tb_tail = 0;
        chk("post_flush_in_ready", in_ready, 1);
        chk("post_flush_req_idle", req_valid, 0);
        chk("post_flush_out_idle", out_valid, 0);
        enq_pc(32'h7000);
        issue(4'd8);
        respond(4'd0);
        chk("stale_0_ignored", out_valid, 0);
        respond(4'd6);
        chk("stale_6_ignored", out_valid, 0);
        respond(4'd8);
        chk("epoch1_accepted", out_valid, 1);
        drain_one("flush");

        // Wrap: move head/tail to 6, fill, then dequeue and enqueue+dequeue
        for (int i = 0; i < 5; i++) enq_pc(32'h8000 + 32'(i * 16));
        for (int i = 0; i < 5; i++) issue((IW+1)'(9 + i));
        for (int i = 0; i < 5; i++) respond((IW+1)'(9 + i));
        for (int i = 0; i < 5; i++) drain_one("prime");
        for (int i = 0; i < 8; i++) begin
            enq_pc(32'h9000 + 32'(i * 16));
            chk("wrap_fill_ready", in_ready, (i < 7));
        end
        for (int i = 0; i < 8; i++) issue((IW+1)'(8 + ((6 + i) % 8)));
        for (int i = 0; i < 8; i++) respond((IW+1)'(8 + ((6 + i) % 8)));
        in_valid = 1'b1; in_pc = 32'hDEAD; out_ready = 1'b1;
        #1;
        chk("full_ready_same_cycle", in_ready, 0);
        sb_check("wrap_deq");
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        chk("ready_after_deq", in_ready, 1);
        for (int j = 0; j < 2; j++) begin
            put_enq(32'hA000 + 32'(j * 16), CW'(j), 1'b1, 32'hA800);
            out_ready = 1'b1;
            sb_check("wrap_enq_deq");
            step();
            in_valid = 1'b0; out_ready = 1'b0;
            chk("count7_in_ready", in_ready, 1);
        end
        enq_pc(32'hB000);
        chk("count_full_again", in_ready, 0);
        issue(4'd14); issue(4'd15); issue(4'd8);
        respond(4'd15); respond(4'd8); respond(4'd14);
        for (int i = 0; i < 8; i++) drain_one("wrap_drain");
        chk("wrap_end_in_ready", in_ready, 1);
        chk("wrap_end_out_valid", out_valid, 0);

        // Reset mid-operation with a request outstanding on entry 1
        enq_pc(32'hC000);
        issue(4'd9);
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready", in_ready, 1);
        chk("arst_req_valid", req_valid, 0);
        chk("arst_out_valid", out_valid, 0);
        step();
        rst_n = 1'b1;
        sb.delete();
        tb_tail = 0;
        respond(4'd1);
        respond(4'd9);
        chk("post_rst_resp_ignored", out_valid, 0);
        chk("post_rst_req_idle", req_valid, 0);
        enq_pc(32'hD000);
        issue(4'd0);
        respond(4'd0);
        drain_one("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
